// File: rtl/reset_sequencer.sv
// Board-level reset generator: synchronises and filters pll_locked, then releases
// NUM_DOMAINS reset domains in index order, re-sequencing on lock loss or software request.
module reset_sequencer #(
  parameter int NUM_DOMAINS     = 4,
  parameter int SYNC_STAGES     = 3,
  parameter int LOCK_FILTER     = 16,
  parameter int STEP_CYCLES     = 8,
  parameter int LED_HALF_PERIOD = 8000000
) (
  input  logic                   CLK_CPU,
  input  logic                   resetp,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] domain_resetp,
  output logic [NUM_DOMAINS-1:0] domain_resetn,
  output logic                   all_released,
  output logic                   seq_busy,
  output logic [7:0]             lock_lost_cnt,
  output logic                   LED
);

  // The state register acts as the last synchroniser stage, so the explicit chain is one shorter.
  localparam int CHAIN = SYNC_STAGES - 1;
  localparam int FW    = $clog2(LOCK_FILTER + 1);
  localparam int SW    = $clog2(STEP_CYCLES + 1);
  localparam int LW    = $clog2(LED_HALF_PERIOD + 1);
  localparam int IW    = $clog2(NUM_DOMAINS + 1);

  localparam logic [FW-1:0] FCNT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_LAST = LW'(LED_HALF_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    FILTER,
    RELEASE,
    RUN,
    SW_HOLD
  } state_t;

  state_t                 state_q;
  logic [CHAIN-1:0]       sync_q;
  logic [CHAIN:0]         sync_in;
  logic                   lock_s;
  logic [FW-1:0]          fcnt_q;
  logic [SW-1:0]          scnt_q;
  logic [LW-1:0]          lcnt_q;
  logic [IW-1:0]          idx_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   all_rel_q;
  logic                   busy_q;
  logic                   led_q;
  logic [7:0]             lost_q;
  logic [7:0]             lost_d;
  logic                   lock_drop;
  logic [NUM_DOMAINS-1:0] rel_mask;

  assign sync_in = {sync_q, pll_locked};
  assign lock_s  = sync_in[CHAIN];

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_in[CHAIN-1:0];
    end
  end

  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel
    assign rel_mask[gi] = (idx_q == IW'(gi));
  end

  assign lock_drop = !lock_s && (state_q == RELEASE || state_q == RUN || state_q == SW_HOLD);
  assign lost_d    = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      state_q   <= WAIT_LOCK;
      fcnt_q    <= '0;
      scnt_q    <= '0;
      lcnt_q    <= '0;
      idx_q     <= '0;
      dom_q     <= '1;
      all_rel_q <= 1'b0;
      busy_q    <= 1'b0;
      led_q     <= 1'b0;
      lost_q    <= '0;
    end else if (!lock_s && state_q != WAIT_LOCK) begin
      // Losing lock anywhere re-asserts every domain; only a loss after filtering is counted.
      state_q   <= WAIT_LOCK;
      dom_q     <= '1;
      all_rel_q <= 1'b0;
      busy_q    <= 1'b0;
      led_q     <= 1'b0;
      if (lock_drop) begin
        lost_q <= lost_d;
      end
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= FILTER;
            fcnt_q  <= '0;
            busy_q  <= 1'b1;
            led_q   <= 1'b1;
          end
        end
        FILTER: begin
          if (fcnt_q == FCNT_LAST) begin
            state_q <= RELEASE;
            idx_q   <= '0;
            scnt_q  <= '0;
          end else begin
            fcnt_q <= fcnt_q + FW'(1);
          end
        end
        RELEASE: begin
          if (scnt_q == SCNT_LAST) begin
            dom_q  <= dom_q & ~rel_mask;
            scnt_q <= '0;
            idx_q  <= idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
              state_q   <= RUN;
              all_rel_q <= 1'b1;
              busy_q    <= 1'b0;
              led_q     <= 1'b1;
              lcnt_q    <= '0;
            end
          end else begin
            scnt_q <= scnt_q + SW'(1);
          end
        end
        RUN: begin
          if (sw_reset_req) begin
            state_q   <= SW_HOLD;
            dom_q     <= '1;
            scnt_q    <= '0;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
            led_q     <= 1'b1;
          end else if (lcnt_q == LCNT_LAST) begin
            led_q  <= ~led_q;
            lcnt_q <= '0;
          end else begin
            lcnt_q <= lcnt_q + LW'(1);
          end
        end
        SW_HOLD: begin
          if (scnt_q == SCNT_LAST) begin
            state_q <= RELEASE;
            idx_q   <= '0;
            scnt_q  <= '0;
          end else begin
            scnt_q <= scnt_q + SW'(1);
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          dom_q   <= '1;
        end
      endcase
    end
  end

  assign domain_resetp = dom_q;
  assign domain_resetn = ~dom_q;
  assign all_released  = all_rel_q;
  assign seq_busy      = busy_q;
  assign lock_lost_cnt = lost_q;
  assign LED           = led_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a timestamp-based model checked every cycle, plus
// hand-computed checkpoints along power-up, glitch, lock loss, software reset and corner runs.
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int SS = 3;
  localparam int LF = 16;
  localparam int ST = 8;
  localparam int HP = 4;
  localparam int K  = SS - 1;

  logic         clk;
  logic         resetp;
  logic         pll;
  logic         sw;
  logic [N-1:0] dom_p;
  logic [N-1:0] dom_n;
  logic         all_rel;
  logic         busy;
  logic [7:0]   lost;
  logic         led;

  int tests = 0;
  int fails = 0;

  reset_sequencer #(
    .NUM_DOMAINS    (N),
    .SYNC_STAGES    (SS),
    .LOCK_FILTER    (LF),
    .STEP_CYCLES    (ST),
    .LED_HALF_PERIOD(HP)
  ) dut (
    .CLK_CPU      (clk),
    .resetp       (resetp),
    .pll_locked   (pll),
    .sw_reset_req (sw),
    .domain_resetp(dom_p),
    .domain_resetn(dom_n),
    .all_released (all_rel),
    .seq_busy     (busy),
    .lock_lost_cnt(lost),
    .LED          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (event timestamps) ----------------
  int           n = 0;
  bit           hist [K];
  bit           m_valid = 0;
  bit           m_active = 0;
  bit           m_filter_kind = 0;
  int           t0 = 0;
  int           lead = 0;
  int           m_lost = 0;
  logic [N-1:0] exp_dom = '1;
  bit           exp_all = 0;
  bit           exp_busy = 0;
  bit           exp_led = 0;

  // Domains released after e edges of a sequence whose first release is at lead+ST.
  function automatic int released(input int e, input int l);
    int r;
    if (e < l) return 0;
    r = (e - l) / ST;
    return (r < N) ? r : N;
  endfunction

  always @(posedge clk) begin
    bit           ls;
    int           ep;
    int           r;
    logic [N-1:0] full;
    n++;
    ls = hist[K-1];
    if (resetp) begin
      for (int i = 0; i < K; i++) hist[i] = 1'b0;
    end else begin
      for (int i = K - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pll;
    end

    if (resetp) begin
      m_valid  = 1;
      m_active = 0;
      m_lost   = 0;
    end else if (!m_active) begin
      if (ls) begin
        m_active      = 1;
        m_filter_kind = 1;
        t0            = n;
        lead          = LF;
      end
    end else begin
      ep = n - 1 - t0;
      if (!ls) begin
        if (!(m_filter_kind && ep < lead)) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
        m_active = 0;
      end else if (sw && released(ep, lead) == N) begin
        t0            = n;
        lead          = ST;
        m_filter_kind = 0;
      end
    end

    full = '1;
    if (!m_active) begin
      exp_dom  = full;
      exp_all  = 0;
      exp_busy = 0;
      exp_led  = 0;
    end else begin
      r        = released(n - t0, lead);
      exp_dom  = full << r;
      exp_all  = (r == N);
      exp_busy = (r < N);
      exp_led  = (r < N) ? 1'b1 : (((n - t0 - lead - N * ST) / HP) % 2 == 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (dom_p !== exp_dom || dom_n !== ~exp_dom || all_rel !== exp_all ||
          busy !== exp_busy || led !== exp_led || lost !== 8'(m_lost)) begin
        fails++;
        $display("FAIL model_cycle_%0d: got dom=%h n=%h all=%b busy=%b led=%b lost=%0d, required dom=%h n=%h all=%b busy=%b led=%b lost=%0d",
                 n, dom_p, dom_n, all_rel, busy, led, lost,
                 exp_dom, ~exp_dom, exp_all, exp_busy, exp_led, m_lost);
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("[TB] %s: %0h ok", name, act);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetp = 1'b1;
    pll    = 1'b1;
    sw     = 1'b0;

    // T1 reset
    cyc(3);
    chk("t1_domain_resetp", 32'(dom_p), 32'hF);
    chk("t1_domain_resetn", 32'(dom_n), 32'h0);
    chk("t1_led", 32'(led), 32'h0);
    chk("t1_lost", 32'(lost), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    resetp = 1'b0;

    // T2 power-up: E0 is the third edge after reset release
    cyc(3);
    chk("t2_e0_busy", 32'(busy), 32'h1);
    chk("t2_e0_dom", 32'(dom_p), 32'hF);
    cyc(20);
    chk("t2_led_solid", 32'(led), 32'h1);
    cyc(3);
    chk("t2_e23_dom", 32'(dom_p), 32'hF);
    cyc(1);
    chk("t2_e24_dom", 32'(dom_p), 32'hE);
    cyc(8);
    chk("t2_e32_dom", 32'(dom_p), 32'hC);
    cyc(8);
    chk("t2_e40_dom", 32'(dom_p), 32'h8);
    cyc(7);
    chk("t2_e47_all", 32'(all_rel), 32'h0);
    cyc(1);
    chk("t2_e48_dom", 32'(dom_p), 32'h0);
    chk("t2_e48_all", 32'(all_rel), 32'h1);
    chk("t2_e48_busy", 32'(busy), 32'h0);

    // T4 lock loss in RUN, then relock (with an ignored sw request during FILTER)
    cyc(5);
    pll = 1'b0;
    cyc(2);
    chk("t4_before_loss_dom", 32'(dom_p), 32'h0);
    cyc(1);
    chk("t4_loss_dom", 32'(dom_p), 32'hF);
    chk("t4_loss_cnt", 32'(lost), 32'h1);
    chk("t4_loss_all", 32'(all_rel), 32'h0);
    pll = 1'b1;
    cyc(3);
    chk("t4_relock_busy", 32'(busy), 32'h1);
    sw = 1'b1;
    cyc(1);
    sw = 1'b0;
    cyc(22);
    chk("t4_e23_dom", 32'(dom_p), 32'hF);
    cyc(1);
    chk("t4_e24_dom", 32'(dom_p), 32'hE);
    cyc(24);
    chk("t4_e48_dom", 32'(dom_p), 32'h0);
    chk("t4_e48_all", 32'(all_rel), 32'h1);

    // T5 software reset in RUN and LED blink
    cyc(2);
    sw = 1'b1;
    cyc(1);
    sw = 1'b0;
    chk("t5_hold_dom", 32'(dom_p), 32'hF);
    chk("t5_hold_busy", 32'(busy), 32'h1);
    chk("t5_hold_all", 32'(all_rel), 32'h0);
    cyc(7);
    chk("t5_s7_dom", 32'(dom_p), 32'hF);
    cyc(1);
    chk("t5_s8_dom", 32'(dom_p), 32'hF);
    cyc(8);
    chk("t5_s16_dom", 32'(dom_p), 32'hE);
    cyc(8);
    chk("t5_s24_dom", 32'(dom_p), 32'hC);
    cyc(16);
    chk("t5_s40_dom", 32'(dom_p), 32'h0);
    chk("t5_s40_led", 32'(led), 32'h1);
    cyc(3);
    chk("t5_r3_led", 32'(led), 32'h1);
    cyc(1);
    chk("t5_r4_led", 32'(led), 32'h0);
    cyc(3);
    chk("t5_r7_led", 32'(led), 32'h0);
    cyc(1);
    chk("t5_r8_led", 32'(led), 32'h1);
    pll = 1'b0;
    cyc(2);
    sw = 1'b1;
    cyc(1);
    sw = 1'b0;
    chk("t5_sw_vs_loss_cnt", 32'(lost), 32'h2);
    chk("t5_sw_vs_loss_busy", 32'(busy), 32'h0);
    chk("t5_sw_vs_loss_dom", 32'(dom_p), 32'hF);
    chk("t5_sw_vs_loss_led", 32'(led), 32'h0);

    // T3 filter glitch: lock_s low at E0+10
    resetp = 1'b1;
    pll    = 1'b1;
    cyc(1);
    resetp = 1'b0;
    chk("t3_reset_cnt", 32'(lost), 32'h0);
    cyc(3);
    cyc(7);
    pll = 1'b0;
    cyc(1);
    pll = 1'b1;
    cyc(1);
    chk("t3_e9_busy", 32'(busy), 32'h1);
    cyc(1);
    chk("t3_e10_busy", 32'(busy), 32'h0);
    chk("t3_e10_led", 32'(led), 32'h0);
    chk("t3_e10_cnt", 32'(lost), 32'h0);
    cyc(1);
    chk("t3_e11_busy", 32'(busy), 32'h1);
    cyc(23);
    chk("t3_e1_23_dom", 32'(dom_p), 32'hF);
    cyc(1);
    chk("t3_e1_24_dom", 32'(dom_p), 32'hE);

    // T6 resetp mid-RELEASE, then saturating lock-loss counter
    cyc(8);
    chk("t6_dom1_released", 32'(dom_p), 32'hC);
    cyc(3);
    resetp = 1'b1;
    cyc(1);
    resetp = 1'b0;
    chk("t6_reset_dom", 32'(dom_p), 32'hF);
    chk("t6_reset_busy", 32'(busy), 32'h0);
    chk("t6_reset_led", 32'(led), 32'h0);
    for (int i = 0; i < 300; i++) begin
      pll = 1'b1;
      cyc(3 + LF + 2);
      pll = 1'b0;
      cyc(3);
      if (i == 253) chk("t6_cnt_254", 32'(lost), 32'd254);
    end
    chk("t6_cnt_saturated", 32'(lost), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
